execute_wb: RTL and testbench

- Downstream neighbour of the operand-select stage.
- Consumes the selected instruction, pointer and operand value; performs PLUS/MINUS arithmetic and resolves BRZ.
- Writes results back to the register file, which unlocks the entry, and issues the branch pulse that the select stage uses to squash its shadow.
- Every modified cell is also queued in a write-through buffer that drains to data memory over a req/ack handshake.

---
 rtl/execute_wb.sv | 193 +++++++++++++++++++
 tb/tb_execute_wb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_wb.sv
`default_nettype none
// ============================================================================
//  Module      : execute_wb
//  Description : Execute / write-back stage. Takes the instruction, pointer
//                and operand chosen by the operand-select stage, performs
//                PLUS / MINUS arithmetic or resolves BRZ, writes the result
//                back to the register file and queues every modified cell in
//                a write-through FIFO that drains to data memory over a
//                req/ack handshake.
//
//  Ports       : clk, rst                    clock, async active-high reset
//                in_valid/in_ins/in_ptr/in_val  instruction from select stage
//                stall_out                   back-pressure to select stage
//                branch_en/branch_target     one-cycle taken-BRZ pulse
//                rf_wr_en/rf_wr_tag/rf_wr_val  register-file write / unlock
//                mem_wr_req/addr/data/ack    write-through FIFO head to memory
//
//  Options     : EXECUTE_WB_COALESCE_EN - when defined, a push to the same
//                address as the youngest FIFO entry overwrites that entry.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_wb #(
    parameter int NCORES   = 4,
    parameter int WB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_ins,
    input  logic [15:0] in_ptr,
    input  logic [15:0] in_val,
    output logic        stall_out,
    output logic        branch_en,
    output logic [15:0] branch_target,
    output logic        rf_wr_en,
    output logic [15:0] rf_wr_tag,
    output logic [15:0] rf_wr_val,
    output logic        mem_wr_req,
    output logic [15:0] mem_wr_addr,
    output logic [15:0] mem_wr_data,
    input  logic        mem_wr_ack
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] c_OP_PLUS  = 4'h1;
    localparam logic [3:0] c_OP_MINUS = 4'h2;
    localparam logic [3:0] c_OP_BRZ   = 4'h5;

    // Pointer wrap relies on natural overflow, so the depth must be 2^n.
    if (NCORES < 1 || WB_DEPTH < 2 || (WB_DEPTH & (WB_DEPTH - 1)) != 0) begin : g_bad_params
        $error("execute_wb: NCORES must be >=1 and WB_DEPTH a power of 2 >= 2");
    end

    // E1 stage
    logic        r_e1_valid;
    logic [15:0] r_e1_ins;
    logic [15:0] r_e1_ptr;
    logic [15:0] r_e1_val;

    // Write-through FIFO
    logic [15:0]      r_addr [WB_DEPTH];
    logic [15:0]      r_data [WB_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    // Output registers
    logic        r_rf_wr_en;
    logic [15:0] r_rf_wr_tag;
    logic [15:0] r_rf_wr_val;
    logic        r_branch_en;
    logic [15:0] r_branch_target;

    logic [3:0]       w_op;
    logic [15:0]      w_imm;
    logic             w_is_arith;
    logic             w_br_taken;
    logic [15:0]      w_result;
    logic             w_pop;
    logic             w_coalesce;
    logic             w_alloc;
    logic [CNT_W-1:0] w_occupancy;
    logic             w_stall;
    logic             w_accept;

    assign w_op       = r_e1_ins[15:12];
    assign w_imm      = {4'h0, r_e1_ins[11:0]};
    assign w_is_arith = r_e1_valid && (w_op == c_OP_PLUS || w_op == c_OP_MINUS);
    assign w_br_taken = r_e1_valid && (w_op == c_OP_BRZ) && (r_e1_val == 16'h0000);
    assign w_result   = (w_op == c_OP_MINUS) ? (r_e1_val - w_imm) : (r_e1_val + w_imm);
    assign w_pop      = (r_count != '0) && mem_wr_ack;

`ifdef EXECUTE_WB_COALESCE_EN
    logic [PTR_W-1:0] w_youngest;
    assign w_youngest = r_tail - 1'b1;
    // With a single entry that is also leaving this cycle, the youngest entry
    // is the head on its way out, so a fresh allocation is required instead.
    assign w_coalesce = w_is_arith && (r_count != '0)
                        && (r_addr[w_youngest] == r_e1_ptr)
                        && !(w_pop && (r_count == CNT_W'(1)));
`else
    assign w_coalesce = 1'b0;
`endif

    assign w_alloc = w_is_arith && !w_coalesce;

    // Worst-case occupancy: assumes the pending E1 result allocates an entry.
    assign w_occupancy = r_count + CNT_W'(w_is_arith);
    assign w_stall     = (w_occupancy >= CNT_W'(WB_DEPTH));
    assign w_accept    = in_valid && !w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e1_valid <= 1'b0;
            r_e1_ins   <= '0;
            r_e1_ptr   <= '0;
            r_e1_val   <= '0;
        end else begin
            r_e1_valid <= w_accept;
            if (w_accept) begin
                r_e1_ins <= in_ins;
                r_e1_ptr <= in_ptr;
                r_e1_val <= in_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf_wr_en      <= 1'b0;
            r_rf_wr_tag     <= '0;
            r_rf_wr_val     <= '0;
            r_branch_en     <= 1'b0;
            r_branch_target <= '0;
        end else begin
            r_rf_wr_en  <= w_is_arith;
            r_branch_en <= w_br_taken;
            if (w_is_arith) begin
                r_rf_wr_tag <= r_e1_ptr;
                r_rf_wr_val <= w_result;
            end
            if (w_br_taken) begin
                r_branch_target <= w_imm;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc) begin
                r_addr[r_tail] <= r_e1_ptr;
                r_data[r_tail] <= w_result;
                r_tail         <= r_tail + 1'b1;
            end
`ifdef EXECUTE_WB_COALESCE_EN
            else if (w_coalesce) begin
                r_data[w_youngest] <= w_result;
            end
`endif
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_alloc, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign stall_out     = w_stall;
    assign branch_en     = r_branch_en;
    assign branch_target = r_branch_target;
    assign rf_wr_en      = r_rf_wr_en;
    assign rf_wr_tag     = r_rf_wr_tag;
    assign rf_wr_val     = r_rf_wr_val;
    assign mem_wr_req    = (r_count != '0);
    assign mem_wr_addr   = r_addr[r_head];
    assign mem_wr_data   = r_data[r_head];

endmodule
`default_nettype wire

// File: tb/tb_execute_wb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_wb
//  Description : Self-checking bench for execute_wb. A cycle model tracks the
//                E1 stage, expected output registers and a scoreboard queue of
//                write-through entries; directed checks pin known values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_wb;

    localparam int WB_DEPTH = 4;
`ifdef EXECUTE_WB_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_ins, in_ptr, in_val;
    logic        stall_out, branch_en, rf_wr_en, mem_wr_req, mem_wr_ack;
    logic [15:0] branch_target, rf_wr_tag, rf_wr_val, mem_wr_addr, mem_wr_data;

    int checks = 0;
    int errors = 0;

    // Model state
    logic        me1_v;
    logic [15:0] me1_ins, me1_ptr, me1_val;
    logic        exp_rf, exp_br;
    logic [15:0] exp_tag, exp_val, exp_tgt;
    logic [31:0] mq[$];

    execute_wb #(.NCORES(4), .WB_DEPTH(WB_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ins(in_ins), .in_ptr(in_ptr), .in_val(in_val),
        .stall_out(stall_out),
        .branch_en(branch_en), .branch_target(branch_target),
        .rf_wr_en(rf_wr_en), .rf_wr_tag(rf_wr_tag), .rf_wr_val(rf_wr_val),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_ack(mem_wr_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        me1_v = 1'b0; me1_ins = '0; me1_ptr = '0; me1_val = '0;
        exp_rf = 1'b0; exp_br = 1'b0; exp_tag = '0; exp_val = '0; exp_tgt = '0;
        mq.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rf_en"},  {15'd0, rf_wr_en},   16'd0);
        chk({tag, "_tag"},    rf_wr_tag,           16'd0);
        chk({tag, "_val"},    rf_wr_val,           16'd0);
        chk({tag, "_br_en"},  {15'd0, branch_en},  16'd0);
        chk({tag, "_tgt"},    branch_target,       16'd0);
        chk({tag, "_req"},    {15'd0, mem_wr_req}, 16'd0);
        chk({tag, "_addr"},   mem_wr_addr,         16'd0);
        chk({tag, "_data"},   mem_wr_data,         16'd0);
        chk({tag, "_stall"},  {15'd0, stall_out},  16'd0);
    endtask

    // One clock: check stall, advance model and DUT, compare outputs.
    task automatic tick();
        logic        mstall, pop, coal, arith;
        logic [3:0]  op;
        logic [15:0] imm, res;
        int          pend;
        op    = me1_ins[15:12];
        imm   = {4'h0, me1_ins[11:0]};
        arith = me1_v && (op == 4'h1 || op == 4'h2);
        pend  = arith ? 1 : 0;
        mstall = (mq.size() + pend) >= WB_DEPTH;
        chk("stall_out", {15'd0, stall_out}, {15'd0, mstall});
        @(posedge clk);
        pop  = (mq.size() != 0) && mem_wr_ack;
        coal = COAL && arith && (mq.size() != 0) && (mq[mq.size()-1][31:16] == me1_ptr)
               && !(pop && mq.size() == 1);
        if (pop) void'(mq.pop_front());
        res = (op == 4'h2) ? me1_val - imm : me1_val + imm;
        exp_rf = arith;
        if (arith) begin
            exp_tag = me1_ptr;
            exp_val = res;
            if (coal) mq[mq.size()-1] = {me1_ptr, res};
            else      mq.push_back({me1_ptr, res});
        end
        exp_br = me1_v && (op == 4'h5) && (me1_val == 16'h0000);
        if (exp_br) exp_tgt = imm;
        me1_v = in_valid && !mstall;
        if (me1_v) begin
            me1_ins = in_ins; me1_ptr = in_ptr; me1_val = in_val;
        end
        #1;
        chk("rf_wr_en", {15'd0, rf_wr_en}, {15'd0, exp_rf});
        if (exp_rf) begin
            chk("rf_wr_tag", rf_wr_tag, exp_tag);
            chk("rf_wr_val", rf_wr_val, exp_val);
        end
        chk("branch_en", {15'd0, branch_en}, {15'd0, exp_br});
        if (exp_br) chk("branch_target", branch_target, exp_tgt);
        chk("mem_wr_req", {15'd0, mem_wr_req}, {15'd0, (mq.size() != 0)});
        if (mq.size() != 0) begin
            chk("mem_wr_addr", mem_wr_addr, mq[0][31:16]);
            chk("mem_wr_data", mem_wr_data, mq[0][15:0]);
        end
    endtask

    task automatic drv(input logic v, input logic [15:0] ins, input logic [15:0] ptr,
                       input logic [15:0] val, input logic ack);
        in_valid = v; in_ins = ins; in_ptr = ptr; in_val = val; mem_wr_ack = ack;
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_ins = '0; in_ptr = '0; in_val = '0; mem_wr_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // PLUS imm=3 ptr=0x10 val=0xFF -> 0x0102, then drained by ack
        drv(1, 16'h1003, 16'h0010, 16'h00FF, 0);
        drv(0, 16'h0000, 16'h0000, 16'h0000, 0);
        chk("t1_rf_en",  {15'd0, rf_wr_en}, 16'd1);
        chk("t1_tag",    rf_wr_tag,   16'h0010);
        chk("t1_val",    rf_wr_val,   16'h0102);
        chk("t1_req",    {15'd0, mem_wr_req}, 16'd1);
        chk("t1_addr",   mem_wr_addr, 16'h0010);
        chk("t1_data",   mem_wr_data, 16'h0102);
        drv(0, 16'h0000, 16'h0000, 16'h0000, 1);
        chk("t1_req_after_ack", {15'd0, mem_wr_req}, 16'd0);

        // Wrap-around arithmetic
        drv(1, 16'h2001, 16'h0020, 16'h0000, 0);
        drv(1, 16'h1001, 16'h0021, 16'hFFFF, 0);
        chk("t2_minus_wrap", rf_wr_val, 16'hFFFF);
        drv(0, 16'h0000, 16'h0000, 16'h0000, 0);
        chk("t2_plus_wrap", rf_wr_val, 16'h0000);
        repeat (3) drv(0, 16'h0000, 16'h0000, 16'h0000, 1);

        // BRZ taken then not taken
        drv(1, 16'h502A, 16'h0030, 16'h0000, 0);
        drv(1, 16'h5011, 16'h0031, 16'h0005, 0);
        chk("t3_br_en",  {15'd0, branch_en}, 16'd1);
        chk("t3_target", branch_target, 16'h002A);
        chk("t3_no_rf",  {15'd0, rf_wr_en}, 16'd0);
        drv(0, 16'h0000, 16'h0000, 16'h0000, 0);
        chk("t3_not_taken", {15'd0, branch_en}, 16'd0);
        chk("t3_no_push",   {15'd0, mem_wr_req}, 16'd0);

        // Fill the FIFO with ack held low, then drain in order
        for (int i = 0; i < 8; i++)
            drv(1, 16'h1000 | 16'(i + 1), 16'h0100 + 16'(i), 16'h0200 + 16'(i * 3), 0);
        chk("t4_stall_full", {15'd0, stall_out}, 16'd1);
        chk("t4_head_addr",  mem_wr_addr, 16'h0100);
        for (int i = 0; i < 6; i++) drv(0, 16'h0000, 16'h0000, 16'h0000, 1);
        chk("t4_drained", {15'd0, mem_wr_req}, 16'd0);

        // Mid-cycle reset with three queued entries
        drv(1, 16'h1001, 16'h0040, 16'h0001, 0);
        drv(1, 16'h1001, 16'h0041, 16'h0002, 0);
        drv(1, 16'h1001, 16'h0042, 16'h0003, 0);
        drv(0, 16'h0000, 16'h0000, 16'h0000, 0);
        drv(0, 16'h0000, 16'h0000, 16'h0000, 0);
        chk("t5_queued", {15'd0, mem_wr_req}, 16'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_all_zero("t5_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        drv(1, 16'h1004, 16'h0050, 16'h0010, 0);
        drv(0, 16'h0000, 16'h0000, 16'h0000, 0);
        chk("t5_fresh_val",  rf_wr_val,   16'h0014);
        chk("t5_fresh_addr", mem_wr_addr, 16'h0050);
        drv(0, 16'h0000, 16'h0000, 16'h0000, 1);
        chk("t5_fresh_pop", {15'd0, mem_wr_req}, 16'd0);

        // Same-address pushes
        drv(1, 16'h1001, 16'h0005, 16'h0001, 0);
        drv(1, 16'h1001, 16'h0005, 16'h0002, 0);
        drv(0, 16'h0000, 16'h0000, 16'h0000, 0);
        drv(0, 16'h0000, 16'h0000, 16'h0000, 0);
`ifdef EXECUTE_WB_COALESCE_EN
        chk("t6_coal_data", mem_wr_data, 16'h0003);
        drv(0, 16'h0000, 16'h0000, 16'h0000, 1);
        chk("t6_coal_one", {15'd0, mem_wr_req}, 16'd0);
`else
        chk("t6_first_data", mem_wr_data, 16'h0002);
        drv(0, 16'h0000, 16'h0000, 16'h0000, 1);
        chk("t6_second_data", mem_wr_data, 16'h0003);
        drv(0, 16'h0000, 16'h0000, 16'h0000, 1);
        chk("t6_two_drained", {15'd0, mem_wr_req}, 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
